// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths, payload type, requester indices and helpers
//               for the writeback port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int TAG_W  = 6;
    localparam int PRD_W  = 7;
    localparam int DATA_W = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_LSU = 2;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [PRD_W-1:0]  prd;
        logic [DATA_W-1:0] data;
        logic              we;
    } wb_payload_t;

    // Position reached after stepping 'off' places from 'base' around a ring of n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Generic NUM_REQ round-robin grant with a registered pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next_ptr;
    logic             w_found;

    // Scan distance k from the pointer; the first valid requester wins.
    always_comb begin
        grant      = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req[i] && (i == wrap_idx(int'(r_ptr), k, NUM_REQ))) begin
                    w_found    = 1'b1;
                    grant[i]   = 1'b1;
                    w_next_ptr = PTR_W'(wrap_idx(i, 1, NUM_REQ));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (update) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Arbitrates NUM_REQ writeback requesters onto one registered
//               MEM/WB bus. Optional macro WB_ARB_LSU_PRIO_EN gives the last
//               requester (LSU) absolute priority.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = wb_pkg::TAG_W,
    parameter int PRD_W   = wb_pkg::PRD_W,
    parameter int DATA_W  = wb_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*PRD_W-1:0]  req_prd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_we,
    output logic                      wb_valid,
    output logic [TAG_W-1:0]          wb_tag,
    output logic [PRD_W-1:0]          wb_prd,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      wb_we
);

    logic [NUM_REQ-1:0] w_rr_req;
    logic [NUM_REQ-1:0] w_rr_grant;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_rr_update;
    logic [TAG_W-1:0]   w_tag;
    logic [PRD_W-1:0]   w_prd;
    logic [DATA_W-1:0]  w_data;
    logic               w_we;

    // Flush hides every request, so neither a grant nor a pointer move happens.
    assign w_rr_req = flush ? '0 : req_valid;

`ifdef WB_ARB_LSU_PRIO_EN
    localparam logic [NUM_REQ-1:0] LSU_ONEHOT = NUM_REQ'(1) << (NUM_REQ - 1);

    logic w_lsu_win;

    assign w_lsu_win   = req_valid[NUM_REQ-1] && !flush;
    assign w_grant     = w_lsu_win ? LSU_ONEHOT : w_rr_grant;
    assign w_rr_update = !w_lsu_win && (|w_rr_grant);
`else
    assign w_grant     = w_rr_grant;
    assign w_rr_update = |w_rr_grant;
`endif

    assign req_ready = w_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .rstn   (rstn),
        .req    (w_rr_req),
        .update (w_rr_update),
        .grant  (w_rr_grant)
    );

    // One-hot grant makes an AND-OR select sufficient.
    always_comb begin
        w_tag  = '0;
        w_prd  = '0;
        w_data = '0;
        w_we   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_tag  = w_tag  | req_tag[i*TAG_W +: TAG_W];
                w_prd  = w_prd  | req_prd[i*PRD_W +: PRD_W];
                w_data = w_data | req_data[i*DATA_W +: DATA_W];
                w_we   = w_we   | req_we[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid <= 1'b0;
            wb_tag   <= '0;
            wb_prd   <= '0;
            wb_data  <= '0;
            wb_we    <= 1'b0;
        end else if (|w_grant) begin
            wb_valid <= 1'b1;
            wb_tag   <= w_tag;
            wb_prd   <= w_prd;
            wb_data  <= w_data;
            wb_we    <= w_we;
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed and randomized checks of wb_port_arbiter against a
//               behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int TW = 6;
    localparam int PW = 7;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_tag;
    logic [N*PW-1:0] req_prd;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_we;
    logic            wb_valid;
    logic [TW-1:0]   wb_tag;
    logic [PW-1:0]   wb_prd;
    logic [DW-1:0]   wb_data;
    logic            wb_we;

    wb_port_arbiter #(
        .NUM_REQ (N),
        .TAG_W   (TW),
        .PRD_W   (PW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_prd   (req_prd),
        .req_data  (req_data),
        .req_we    (req_we),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_prd    (wb_prd),
        .wb_data   (wb_data),
        .wb_we     (wb_we)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Requester-side state and model state
    logic [N-1:0]  rv;
    logic [TW-1:0] rq_tag  [N];
    logic [PW-1:0] rq_prd  [N];
    logic [DW-1:0] rq_data [N];
    logic          rq_we   [N];
    int            m_ptr;
    logic          e_valid;
    logic [TW-1:0] e_tag;
    logic [PW-1:0] e_prd;
    logic [DW-1:0] e_data;
    logic          e_we;
    logic [N-1:0]  g;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        rq_tag[i]  = TW'($urandom);
        rq_prd[i]  = PW'($urandom);
        rq_data[i] = $urandom;
        rq_we[i]   = 1'($urandom);
    endtask

    task automatic drive();
        req_valid = rv;
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW]  = rq_tag[i];
            req_prd[i*PW +: PW]  = rq_prd[i];
            req_data[i*DW +: DW] = rq_data[i];
            req_we[i]            = rq_we[i];
        end
    endtask

    // Winner by rule: nothing under flush; LSU first when prioritised;
    // otherwise the first valid one met walking up from the pointer.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input logic f, input int ptr);
        logic [N-1:0] r;
        r = '0;
        if (f || v == '0) return r;
`ifdef WB_ARB_LSU_PRIO_EN
        if (v[N-1]) begin
            r[N-1] = 1'b1;
            return r;
        end
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) begin
                r[(ptr + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        e_valid = 1'b0;
        e_tag   = '0;
        e_prd   = '0;
        e_data  = '0;
        e_we    = 1'b0;
    endtask

    task automatic check_wb(input string nm);
        check({nm, "/wb_valid"}, 64'(wb_valid), 64'(e_valid));
        check({nm, "/wb_tag"},   64'(wb_tag),   64'(e_tag));
        check({nm, "/wb_prd"},   64'(wb_prd),   64'(e_prd));
        check({nm, "/wb_data"},  64'(wb_data),  64'(e_data));
        check({nm, "/wb_we"},    64'(wb_we),    64'(e_we));
    endtask

    // One clock: check the combinational grant, then the registered bus.
    task automatic do_cycle(input string nm, output logic [N-1:0] gnt);
        logic [N-1:0] exp_g;
        drive();
        #2;
        exp_g = model_grant(rv, flush, m_ptr);
        check({nm, "/req_ready"}, 64'(req_ready), 64'(exp_g));
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (exp_g[i]) begin
                e_valid = 1'b1;
                e_tag   = rq_tag[i];
                e_prd   = rq_prd[i];
                e_data  = rq_data[i];
                e_we    = rq_we[i];
`ifdef WB_ARB_LSU_PRIO_EN
                if (i != N - 1) m_ptr = (i + 1) % N;
`else
                m_ptr = (i + 1) % N;
`endif
            end
        end
        check_wb(nm);
        gnt = exp_g;
    endtask

    initial begin
        rstn  = 1'b0;
        flush = 1'b0;
        rv    = '0;
        for (int i = 0; i < N; i++) new_payload(i);
        drive();
        model_reset();

        // Reset state
        #12;
        check_wb("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        do_cycle("idle", g);

        // Single request on MUL
        rv         = 3'b010;
        rq_tag[1]  = 6'd5;
        rq_data[1] = 32'hDEAD;
        do_cycle("single", g);
        check("single/ready_const", 64'(g), 64'(3'b010));
        check("single/tag_const",  64'(wb_tag),  64'd5);
        check("single/data_const", 64'(wb_data), 64'hDEAD);

        // Wrap from pointer 2 to requester 0
        rv = 3'b011;
        new_payload(1);
        do_cycle("wrap0", g);
        new_payload(0);
        rv = 3'b010;
        do_cycle("wrap1", g);

        // Flush blocks the grant and keeps the pointer
        rv    = 3'b111;
        flush = 1'b1;
        do_cycle("flush", g);
        flush = 1'b0;
        do_cycle("post_flush", g);

        // Continuous requests from all
        for (int c = 0; c < 6; c++) begin
            do_cycle($sformatf("all%0d", c), g);
            for (int i = 0; i < N; i++) if (g[i]) new_payload(i);
        end
        rv = '0;
        do_cycle("drain", g);

        // Randomized traffic with hold-until-accepted requesters
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && ($urandom % 2 == 0)) begin
                    rv[i] = 1'b1;
                    new_payload(i);
                end
            end
            flush = ($urandom % 8 == 0);
            do_cycle($sformatf("rand%0d", c), g);
            for (int i = 0; i < N; i++) if (g[i]) rv[i] = 1'b0;
        end
        flush = 1'b0;

        // Reset asserted in the middle of a transfer
        rv = 3'b111;
        do_cycle("pre_rst", g);
        drive();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_wb("mid_rst");
        rv = '0;
        drive();
        @(posedge clk);
        #1;
        check_wb("in_rst");
        rstn = 1'b1;
        do_cycle("rst_release", g);
        rv = 3'b111;
        do_cycle("rst_first", g);
`ifndef WB_ARB_LSU_PRIO_EN
        check("rst_first/grant0", 64'(g), 64'(3'b001));
`endif
        rv = '0;
        do_cycle("end", g);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of writeback requesters (0=ALU, 1=MUL, 2=LSU).
REQ-002 The block SHALL have parameter TAG_W, default 6, giving the ROB tag width.
REQ-003 The block SHALL have parameter PRD_W, default 7, giving the physical destination register index width.
REQ-004 The block SHALL have parameter DATA_W, default 32, giving the result data width.
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1, clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port flush, input, 1, pipeline flush (mispredict or exception).
REQ-008 The block SHALL have port req_valid, input, NUM_REQ, per-requester valid.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ, per-requester grant/accept.
REQ-010 The block SHALL have ports req_tag, req_prd, req_data and req_we, inputs, packed NUM_REQ x TAG_W, PRD_W, DATA_W and 1 respectively, per-requester payload.
REQ-011 The block SHALL have ports wb_valid, wb_tag, wb_prd, wb_data and wb_we, outputs, registered, forming the single MEM/WB writeback bus (no backpressure).

Function
REQ-012 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-013 req_ready SHALL be combinational, one-hot or zero, with at most one grant per cycle.
REQ-014 The grant SHALL go to the first valid requester found scanning upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-015 req_ready SHALL be all-zero whenever flush=1 or req_valid=0.
REQ-016 On a transfer in cycle t, the granted payload SHALL appear on wb_* with wb_valid=1 in cycle t+1 (latency 1).
REQ-017 wb_valid SHALL be high for exactly one cycle per transfer.
REQ-018 When there is no transfer, wb_valid SHALL be 0 and wb_tag/wb_prd/wb_data/wb_we SHALL hold their previous values.
REQ-019 rr_ptr SHALL advance to (granted index + 1) mod NUM_REQ after each transfer, and SHALL be unchanged otherwise.
REQ-020 flush=1 in cycle t SHALL force wb_valid=0 in cycle t+1 and leave rr_ptr unchanged.
REQ-021 A wb_valid already high in cycle t SHALL NOT be suppressed by flush in cycle t.
REQ-022 Requesters SHALL hold valid and payload stable until accepted; the arbiter SHALL NOT depend on req_* of non-valid requesters.
REQ-023 With continuous requests from all requesters, each requester SHALL be granted at least once every NUM_REQ cycles (round-robin mode).
REQ-024 req_we SHALL pass through unmodified; tag 0 and prd 0 SHALL NOT be treated specially.

Reset
REQ-025 When rstn=0, asynchronously: wb_valid=0, wb_tag=0, wb_prd=0, wb_data=0, wb_we=0 and rr_ptr=0.
REQ-026 Assertion of rstn mid-transfer SHALL discard that transfer; the first cycle after release SHALL have wb_valid=0.

Configuration
REQ-027 Macro WB_ARB_LSU_PRIO_EN SHALL control LSU priority; it is undefined by default.
REQ-028 With WB_ARB_LSU_PRIO_EN defined, requester NUM_REQ-1 SHALL win whenever valid; other requesters use round-robin; rr_ptr is unchanged on an LSU grant.
REQ-029 Without WB_ARB_LSU_PRIO_EN, pure round-robin per REQ-014 SHALL apply.

Structure
REQ-030 Package wb_pkg SHALL hold the widths TAG_W, PRD_W and DATA_W, the wb_payload_t struct {tag, prd, data, we}, and the requester index constants REQ_ALU, REQ_MUL and REQ_LSU.
REQ-031 Sub-module rr_arbiter SHALL implement the generic NUM_REQ round-robin grant and pointer; wb_port_arbiter SHALL add flush gating, the LSU override and the output register.

Verification
REQ-032 Single request: req_valid=3'b010, tag=5, data=0xDEAD -> req_ready=3'b010 in the same cycle; next cycle wb_valid=1, wb_tag=5, wb_data=0xDEAD.
REQ-033 All requesting continuously, rr_ptr=0 after reset -> grant order 0,1,2,0,1,2; six wb_valid pulses in six consecutive cycles.
REQ-034 Wrap: rr_ptr=2 with req_valid=3'b011 -> grant 0, then rr_ptr=1.
REQ-035 Flush: req_valid=3'b111 and flush=1 in cycle t -> req_ready=0 and wb_valid=0 in t+1; with flush=0 in t+1, the grant uses the unchanged rr_ptr.
REQ-036 LSU priority (macro on): req_valid=3'b111 for three cycles -> req_ready=3'b100 each cycle; after LSU drops, round-robin resumes from the unchanged rr_ptr.
REQ-037 Reset mid-stream: rstn low during a transfer -> wb_* go to 0 immediately; after release the first grant goes to requester 0.
